list_cmd_sequencer: RTL and testbench

LIST_CMD_SEQUENCER -- requirements
Module: list_cmd_sequencer

---
 rtl/list_cmd_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_list_cmd_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_cmd_sequencer.sv
// rtl/list_cmd_sequencer.sv - issues one list command at a time and queues its responses
// Response FIFO helper plus the IDLE/ISSUE/WAIT command sequencer.

module list_rsp_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    free_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign free_cnt = CW'(DEPTH) - count;
  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // Zero the head when empty so the response outputs read as 0 after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

module list_cmd_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  parameter int RSP_DEPTH  = 16,
  parameter int TIMEOUT    = 1024,
  localparam int IW = $clog2(LENGTH),
  localparam int RW = IW + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [IW-1:0]         cmd_index,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RW-1:0]         rsp_data,
  output logic                  rsp_error,
  output logic                  rsp_last,
  output logic                  rsp_timeout,
  output logic [2:0]            list_op_sel,
  output logic                  list_op_en,
  output logic [DATA_WIDTH-1:0] list_data_in,
  output logic [IW-1:0]         list_index_in,
  input  logic [RW-1:0]         list_data_out,
  input  logic                  list_op_done,
  input  logic                  list_op_in_progress,
  input  logic                  list_op_error,
  output logic                  busy
);

  localparam int FW = RW + 3;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SLOTS_NEEDED = CW'(LENGTH + 1);
  localparam logic [TW-1:0] WDOG_LAST    = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]    state;
  logic          seen_busy;
  logic [TW-1:0] wdog;
  logic          cmd_fire;
  logic          final_hit;
  logic          inter_hit;
  logic          tmo_hit;
  logic          rsp_push;
  logic [FW-1:0] rsp_word;
  logic [FW-1:0] head_word;
  logic          rsp_empty;
  logic [CW-1:0] free_cnt;

  // Admission needs room for every response one command can produce (up to LENGTH matches + final).
  assign cmd_ready  = !rst && (state == IDLE) && (free_cnt >= SLOTS_NEEDED);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign list_op_en = (state == ISSUE);
  assign busy       = (state == ISSUE) || (state == WAIT);

  assign final_hit = (state == WAIT) && !list_op_in_progress && (list_op_done || seen_busy);
  assign inter_hit = (state == WAIT) && list_op_done && list_op_in_progress;
  assign tmo_hit   = (state == WAIT) && (wdog == WDOG_LAST);

  // Word layout: {data, error, last, timeout}. A real final wins over the watchdog.
  always_comb begin
    rsp_push = 1'b0;
    rsp_word = '0;
    if (final_hit) begin
      rsp_push = 1'b1;
      rsp_word = {list_data_out, list_op_error, 1'b1, 1'b0};
    end else if (tmo_hit) begin
      rsp_push = 1'b1;
      rsp_word = {{RW{1'b0}}, 1'b1, 1'b1, 1'b1};
    end else if (inter_hit) begin
      rsp_push = 1'b1;
      rsp_word = {list_data_out, list_op_error, 1'b0, 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      list_op_sel   <= '0;
      list_data_in  <= '0;
      list_index_in <= '0;
      seen_busy     <= 1'b0;
      wdog          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            list_op_sel   <= cmd_op;
            list_data_in  <= cmd_data;
            list_index_in <= cmd_index;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          seen_busy <= 1'b0;
          wdog      <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (list_op_in_progress) begin
            seen_busy <= 1'b1;
          end
          if (final_hit || tmo_hit) begin
            state <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  list_rsp_fifo #(
    .WIDTH(FW),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_push),
    .push_data(rsp_word),
    .pop      (rsp_ready),
    .pop_data (head_word),
    .empty    (rsp_empty),
    .free_cnt (free_cnt)
  );

  assign rsp_valid   = !rsp_empty;
  assign rsp_data    = head_word[FW-1:3];
  assign rsp_error   = head_word[2];
  assign rsp_last    = head_word[1];
  assign rsp_timeout = head_word[0];

endmodule

// File: tb/tb_list_cmd_sequencer.sv
// tb/tb_list_cmd_sequencer.sv - scoreboard bench with a behavioural list model
module tb_list_cmd_sequencer;

  localparam int DW  = 32;
  localparam int LEN = 8;
  localparam int RD  = 16;
  localparam int TMO = 64;
  localparam int IW  = 3;
  localparam int RW  = 35;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [IW-1:0] cmd_index = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [RW-1:0] rsp_data;
  logic          rsp_error, rsp_last, rsp_timeout;
  logic [2:0]    list_op_sel;
  logic          list_op_en;
  logic [DW-1:0] list_data_in;
  logic [IW-1:0] list_index_in;
  logic [RW-1:0] list_data_out = '0;
  logic          list_op_done = 1'b0;
  logic          list_op_in_progress = 1'b0;
  logic          list_op_error = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  list_cmd_sequencer #(
    .DATA_WIDTH(DW), .LENGTH(LEN), .RSP_DEPTH(RD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_index(cmd_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_last(rsp_last), .rsp_timeout(rsp_timeout),
    .list_op_sel(list_op_sel), .list_op_en(list_op_en),
    .list_data_in(list_data_in), .list_index_in(list_index_in),
    .list_data_out(list_data_out), .list_op_done(list_op_done),
    .list_op_in_progress(list_op_in_progress), .list_op_error(list_op_error),
    .busy(busy)
  );

  typedef struct packed {
    logic [RW-1:0] data;
    logic          err;
    logic          last;
    logic          tmo;
  } item_t;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          silent;
    logic          seq;
    logic [7:0]    n;
  } plan_t;

  item_t         exp_q[$];
  item_t         drive_q[$];
  item_t         cur_q[$];
  plan_t         plan_q[$];
  logic [DW-1:0] gl[$];
  plan_t         cur_plan;
  bit            hold_ok;
  bit            hold_rsp = 1'b1;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_item(input logic [RW-1:0] d, input logic e, input logic l);
    item_t it;
    it.data = d; it.err = e; it.last = l; it.tmo = 1'b0;
    cur_q.push_back(it);
  endfunction

  // Reference list semantics: what the downstream list reports for each opcode.
  task automatic compute(input logic [2:0] op, input logic [DW-1:0] d, input logic [IW-1:0] idx);
    int cnt;
    int first;
    logic [RW-1:0] s;
    logic [DW-1:0] t;
    cur_q.delete();
    case (op)
      3'd0: if (int'(idx) < gl.size()) add_item(RW'(gl[idx]), 1'b0, 1'b1);
            else add_item('0, 1'b1, 1'b1);
      3'd1: if (gl.size() < LEN && int'(idx) <= gl.size()) begin
              gl.insert(int'(idx), d);
              add_item('0, 1'b0, 1'b1);
            end else add_item('0, 1'b1, 1'b1);
      3'd2: begin
        cnt = 0;
        for (int i = 0; i < gl.size(); i++)
          if (gl[i] == d) begin add_item(RW'(i), 1'b0, 1'b0); cnt++; end
        add_item(RW'(cnt), 1'b0, 1'b1);
      end
      3'd3: begin
        first = -1;
        for (int i = gl.size() - 1; i >= 0; i--) if (gl[i] == d) first = i;
        if (first >= 0) add_item(RW'(first), 1'b0, 1'b1);
        else add_item('0, 1'b1, 1'b1);
      end
      3'd4: begin
        s = '0;
        for (int i = 0; i < gl.size(); i++) s = s + RW'(gl[i]);
        add_item(s, 1'b0, 1'b1);
      end
      3'd5, 3'd6: begin
        for (int i = 0; i < gl.size(); i++)
          for (int j = 0; j < gl.size() - 1 - i; j++)
            if ((op == 3'd5) ? (gl[j] > gl[j+1]) : (gl[j] < gl[j+1])) begin
              t = gl[j]; gl[j] = gl[j+1]; gl[j+1] = t;
            end
        add_item('0, 1'b0, 1'b1);
      end
      default: if (int'(idx) < gl.size()) begin
                 gl.delete(int'(idx));
                 add_item('0, 1'b0, 1'b1);
               end else add_item('0, 1'b1, 1'b1);
    endcase
  endtask

  task automatic send(input logic [2:0] op, input logic [DW-1:0] d, input logic [IW-1:0] idx,
                      input bit silent, input bit score);
    plan_t p;
    item_t it;
    int n;
    if (silent) begin
      cur_q.delete();
      it.data = '0; it.err = 1'b1; it.last = 1'b1; it.tmo = 1'b1;
      if (score) exp_q.push_back(it);
    end else begin
      compute(op, d, idx);
      foreach (cur_q[i]) begin
        drive_q.push_back(cur_q[i]);
        if (score) exp_q.push_back(cur_q[i]);
      end
    end
    p.op = op; p.data = d; p.idx = idx; p.silent = silent;
    p.seq = (op == 3'd4) || ($urandom_range(0, 3) == 0);
    p.n = 8'(cur_q.size());
    plan_q.push_back(p);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_index = idx;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 3000);
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL cmd_accept: cmd_ready never rose for op %0d", op);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = $urandom; cmd_index = IW'($urandom);
  endtask

  task automatic drv(input logic ip, input logic dn, input logic [RW-1:0] d, input logic e);
    list_op_in_progress = ip; list_op_done = dn; list_data_out = d; list_op_error = e;
    @(negedge clk);
    if (list_op_sel !== cur_plan.op || list_data_in !== cur_plan.data ||
        list_index_in !== cur_plan.idx || list_op_en !== 1'b0 || busy !== 1'b1)
      hold_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_plan();
    item_t it;
    hold_ok = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < int'(cur_plan.n); k++) begin
      it = drive_q.pop_front();
      if (!it.last) begin
        repeat ($urandom_range(0, 2)) drv(1'b1, 1'b0, RW'($urandom), 1'b1);
        drv(1'b1, 1'b1, it.data, it.err);
      end else if (cur_plan.seq) begin
        repeat ($urandom_range(1, 3)) drv(1'b1, 1'b0, RW'($urandom), 1'b1);
        drv(1'b0, 1'b0, it.data, it.err);
      end else begin
        repeat ($urandom_range(0, 2)) drv(1'b1, 1'b0, RW'($urandom), 1'b1);
        drv(1'b0, 1'b1, it.data, it.err);
      end
    end
    list_op_in_progress = 1'b0; list_op_done = 1'b0; list_data_out = RW'($urandom);
    @(negedge clk);
    check("operand_hold", hold_ok, 1'b1);
    check("idle_after_final", {busy, list_op_en}, 2'b00);
  endtask

  // Downstream list: reacts to each list_op_en with the planned response sequence.
  initial begin
    bit prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_en) check("op_en_single_cycle", list_op_en, 1'b0);
      prev_en = list_op_en;
      if (list_op_en === 1'b1) begin
        if (plan_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_issue: op %0d with no pending command", list_op_sel);
        end else begin
          cur_plan = plan_q.pop_front();
          check("issue_operands", {busy, list_op_sel, list_data_in, list_index_in},
                {1'b1, cur_plan.op, cur_plan.data, cur_plan.idx});
          if (!cur_plan.silent) begin
            run_plan();
            prev_en = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every accepted response is compared with the head of the scoreboard.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected: data 0x%0h err %0b last %0b tmo %0b",
                   rsp_data, rsp_error, rsp_last, rsp_timeout);
        end else begin
          e = exp_q.pop_front();
          check("rsp", {rsp_data, rsp_error, rsp_last, rsp_timeout}, e);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    bit low_ok;
    @(negedge clk);
    check("reset_outputs", {cmd_ready, rsp_valid, busy, list_op_en, list_op_sel,
                            list_data_in, list_index_in, rsp_data, rsp_error, rsp_last, rsp_timeout}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);
    hold_rsp = 1'b0;

    send(3'd1, 32'h5, 3'd0, 0, 1);
    send(3'd0, 32'h0, 3'd0, 0, 1);
    send(3'd0, 32'h0, 3'd3, 0, 1);
    send(3'd7, 32'h0, 3'd0, 0, 1);
    send(3'd1, 32'h7, 3'd0, 0, 1);
    send(3'd1, 32'h2, 3'd1, 0, 1);
    send(3'd1, 32'h7, 3'd2, 0, 1);
    send(3'd2, 32'h7, 3'd0, 0, 1);
    repeat (3) send(3'd7, 32'h0, 3'd0, 0, 1);
    for (int i = 0; i < 3; i++) send(3'd1, DW'(i + 1), IW'(i), 0, 1);
    send(3'd4, 32'h0, 3'd0, 0, 1);
    drain();

    hold_rsp = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < LEN; i++) send(3'd0, 32'h0, IW'(i), 0, 1);
    repeat (40) @(negedge clk);
    low_ok = 1'b1;
    repeat (10) begin @(negedge clk); if (cmd_ready || !rsp_valid) low_ok = 1'b0; end
    check("backpressure_blocks_cmd", low_ok, 1'b1);
    hold_rsp = 1'b0;
    for (int i = 0; i < LEN; i++) send(3'd0, 32'h0, IW'(i), 0, 1);
    drain();

    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom);
      send(op, ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 5)),
           IW'($urandom), $urandom_range(0, 39) == 0, 1);
    end
    drain();

    send(3'd0, 32'h0, 3'd0, 1, 1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 4 * TMO) begin @(negedge clk); n++; end
    check("timeout_latency", n, TMO + 1);
    drain();

    hold_rsp = 1'b1;
    send(3'd0, 32'h0, 3'd0, 0, 1);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    send(3'd5, 32'h0, 3'd0, 1, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_wait_reset", {rsp_valid, busy, cmd_ready, list_op_en}, 4'b0000);
    exp_q.delete(); plan_q.delete(); drive_q.delete();
    @(posedge clk); #1 rst = 1'b0; hold_rsp = 1'b0;
    @(negedge clk);
    check("after_mid_reset", {cmd_ready, rsp_valid}, 2'b10);
    send(3'd0, 32'h0, 3'd0, 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
